// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-port register file.
//   Two write ports (port 1 wins on an address collision), NUM_RD combinational
//   read ports, an optional hard-wired zero entry, and a clear engine that
//   zeroes every entry, one per clock, after reset. The core is held off
//   through busy while the clear runs.
//
// Optional feature: define RF_BYPASS_EN to forward same-cycle write data to
//   matching read ports. Without it, a same-cycle read returns the old value.
//
// Ports:
//   clk            clock, all state changes on the rising edge
//   rst            synchronous active-high reset (starts the clear engine)
//   ra  [NUM_RD*ADDR_W]  read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd  [NUM_RD*DATA_W]  read data,      port i at [i*DATA_W +: DATA_W]
//   we0/wa0/wd0    write port 0 (ALU writeback)
//   we1/wa1/wd1    write port 1 (load writeback)
//   busy           clear engine active: writes dropped, reads return 0
`default_nettype none

module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   ra,
  output logic [NUM_RD*DATA_W-1:0]   rd,
  input  logic                       we0,
  input  logic [ADDR_W-1:0]          wa0,
  input  logic [DATA_W-1:0]          wd0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          wa1,
  input  logic [DATA_W-1:0]          wd1,
  output logic                       busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   clr_idx;
  logic [DATA_W-1:0]   rf [DEPTH];

  // Write-port qualifiers; entry 0 swallows writes when it is the zero register.
  logic wr0, wr1;
  assign wr0 = we0 && !((ZERO_REG == 1) && (wa0 == '0));
  assign wr1 = we1 && !((ZERO_REG == 1) && (wa1 == '0));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state <= state_nxt;
      // Wraps to 0 on the final clear edge, ready for the next reset.
      if (state == CLEAR) clr_idx <= clr_idx + ADDR_W'(1);
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_idx == ADDR_W'(DEPTH - 1)) state_nxt = READY;
      READY:   state_nxt = READY;
      default: state_nxt = CLEAR;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (state != READY);
  end

  // ---------------- storage ----------------
  // No reset on the array: the reset edge itself leaves contents alone, the
  // clear engine does the zeroing afterwards. Port 1 is written last so it
  // wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        rf[clr_idx] <= '0;
      end else begin
        if (wr0) rf[wa0] <= wd0;
        if (wr1) rf[wa1] <= wd1;
      end
    end
  end

  // ---------------- read ports ----------------
  logic [ADDR_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_v;

  always_comb begin
    rd   = '0;
    rd_a = '0;
    rd_v = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_a = ra[i*ADDR_W +: ADDR_W];
      rd_v = rf[rd_a];
`ifdef RF_BYPASS_EN
      // Port 1 checked first so it beats port 0 on a double match.
      if (we1 && (wa1 == rd_a))      rd_v = wd1;
      else if (we0 && (wa0 == rd_a)) rd_v = wd0;
`endif
      // Masking last: covers both busy and the zero register, bypass included.
      if (busy || ((ZERO_REG == 1) && (rd_a == '0))) rd_v = '0;
      rd[i*DATA_W +: DATA_W] = rd_v;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp. Two instances share all inputs: u_z has
// ZERO_REG=1, u_n has ZERO_REG=0. Inputs change on the falling edge and
// outputs are sampled 1 ns later; state changes on the rising edge.
`timescale 1ns/1ps

module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic            clk;
  logic            rst;
  logic [NR*AW-1:0] ra;
  logic [NR*DW-1:0] rd_z, rd_n;
  logic            we0, we1;
  logic [AW-1:0]   wa0, wa1;
  logic [DW-1:0]   wd0, wd1;
  logic            busy_z, busy_n;

  int n_chk = 0;
  int n_err = 0;
  int cnt;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) u_z (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd_z),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .busy(busy_z)
  );

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0)) u_n (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd_n),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .busy(busy_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] p0(input logic [NR*DW-1:0] v);
    return v[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] p1(input logic [NR*DW-1:0] v);
    return v[2*DW-1:DW];
  endfunction

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0;
    wa0 = '0;   wa1 = '0;
    wd0 = '0;   wd1 = '0;
  endtask

  // Counts falling edges with busy high, starting at the one right after the
  // reset edge. While busy, pokes port 0 at address 2 (already cleared by
  // then) so a leaked write would survive the clear.
  task automatic count_busy(output int n, input bit poke);
    n = 0;
    while (busy_z === 1'b1 && n < 100) begin
      if (poke && n > 5) begin
        we0 = 1'b1; wa0 = 5'd2; wd0 = 32'hBAD0_0002;
      end
      ra = {5'd2, 5'd31};
      #1;
      if (n == 3) begin
        chk("busy_rd0", {32'h0, p0(rd_z)}, 64'h0);
        chk("busy_rd1", {32'h0, p1(rd_n)}, 64'h0);
      end
      n++;
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    ra  = '0;
    idle();

    // ---- reset then full clear ----
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rst_busy", {63'h0, busy_z}, 64'h1);
    count_busy(cnt, 1'b0);
    chk("clr_len", 64'(cnt), 64'd32);
    #1;
    chk("ready_z", {63'h0, busy_z}, 64'h0);
    chk("ready_n", {63'h0, busy_n}, 64'h0);

    for (int a = 0; a < 16; a++) begin
      ra = {5'(a + 16), 5'(a)};
      #1;
      chk($sformatf("clr_rd_%0d", a),      {32'h0, p0(rd_n)}, 64'h0);
      chk($sformatf("clr_rd_%0d", a + 16), {32'h0, p1(rd_n)}, 64'h0);
    end

    // ---- basic write / read ----
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd17; wd0 = 32'h4321_4321;
    @(negedge clk);
    idle();
    ra = {5'd0, 5'd17};
    #1;
    chk("wr17", {32'h0, p0(rd_z)}, {32'h0, 32'h4321_4321});
    chk("rd0_zero", {32'h0, p1(rd_z)}, 64'h0);

    // ---- write collision: port 1 wins ----
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd8; wd0 = 32'h1111_1111;
    we1 = 1'b1; wa1 = 5'd8; wd1 = 32'h2222_2222;
    @(negedge clk);
    idle();
    ra = {5'd17, 5'd8};
    #1;
    chk("collide", {32'h0, p0(rd_z)}, {32'h0, 32'h2222_2222});
    chk("keep17",  {32'h0, p1(rd_z)}, {32'h0, 32'h4321_4321});

    // ---- zero register ----
    @(negedge clk);
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF;
    @(negedge clk);
    idle();
    ra = {5'd0, 5'd0};
    #1;
    chk("zreg_on",  {32'h0, p0(rd_z)}, 64'h0);
    chk("zreg_off", {32'h0, p0(rd_n)}, {32'h0, 32'hFFFF_FFFF});

    // ---- same-cycle read of a written address ----
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h0000_0033;
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hA5A5_A5A5;
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'h1234_5678;
    ra  = {5'd0, 5'd3};
    #1;
`ifdef RF_BYPASS_EN
    chk("byp_rd",   {32'h0, p0(rd_z)}, {32'h0, 32'hA5A5_A5A5});
    chk("byp_zoff", {32'h0, p1(rd_n)}, {32'h0, 32'h1234_5678});
`else
    chk("byp_rd",   {32'h0, p0(rd_z)}, {32'h0, 32'h0000_0033});
    chk("byp_zoff", {32'h0, p1(rd_n)}, {32'h0, 32'hFFFF_FFFF});
`endif
    chk("byp_zon",  {32'h0, p1(rd_z)}, 64'h0);
    @(negedge clk);
    idle();
    #1;
    chk("after_wr3", {32'h0, p0(rd_z)}, {32'h0, 32'hA5A5_A5A5});
    chk("after_w0n", {32'h0, p1(rd_n)}, {32'h0, 32'h1234_5678});

    // double match: port 1 data forwarded
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h0000_0044;
    we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h0000_0055;
    ra  = {5'd4, 5'd4};
    #1;
`ifdef RF_BYPASS_EN
    chk("byp_dbl", {32'h0, p1(rd_z)}, {32'h0, 32'h0000_0055});
`else
    chk("byp_dbl", {32'h0, p1(rd_z)}, 64'h0);
`endif
    @(negedge clk);
    idle();
    #1;
    chk("dbl_wr", {32'h0, p0(rd_z)}, {32'h0, 32'h0000_0055});

    // ---- reset mid-clear ----
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd31; wd0 = 32'hDEAD_BEEF;
    @(negedge clk);
    idle();
    ra = {5'd0, 5'd31};
    #1;
    chk("wr31", {32'h0, p0(rd_z)}, {32'h0, 32'hDEAD_BEEF});

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      we0 = 1'b1; wa0 = 5'd31; wd0 = 32'hDEAD_BEEF;
      #1;
      if (k == 5) chk("mid_busy", {63'h0, busy_z}, 64'h1);
      @(negedge clk);
    end
    idle();
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rerst_busy", {63'h0, busy_z}, 64'h1);
    count_busy(cnt, 1'b1);
    chk("reclr_len", 64'(cnt), 64'd32);
    ra = {5'd2, 5'd31};
    #1;
    chk("reclr_31", {32'h0, p0(rd_z)}, 64'h0);
    chk("drop_wr2", {32'h0, p1(rd_z)}, 64'h0);
    ra = {5'd17, 5'd8};
    #1;
    chk("reclr_8",  {32'h0, p0(rd_n)}, 64'h0);
    chk("reclr_17", {32'h0, p1(rd_n)}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
